// File: rtl/pause_pkg.sv
// -----------------------------------------------------------------------------
// pause_pkg
// Shared definitions for the frame-aligned pause sequencer:
//   - pause_state_t : sequencer state encoding (also exported for debug)
//   - OPT_*         : bit positions inside the 2-bit options word
//   - dim_cycles()  : clk_sys cycles of continuous pause before dimming
// -----------------------------------------------------------------------------
package pause_pkg;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      WAIT_VBL = 3'd1,
      HALTING  = 3'd2,
      PAUSED   = 3'd3,
      RESUMING = 3'd4
   } pause_state_t;

   // options[OPT_OSD_PAUSE] : pause while the OSD is open
   // options[OPT_DIM_EN]    : burn-in dimming enabled
   localparam int OPT_OSD_PAUSE = 0;
   localparam int OPT_DIM_EN    = 1;

   // Clock in MHz times seconds; 12 MHz * 10 s = 120e6 fits comfortably in 32 bits.
   function automatic logic [31:0] dim_cycles(input int unsigned clkspd,
                                              input int unsigned secs);
      return 32'(clkspd * 32'd1000000 * secs);
   endfunction

endpackage

// File: rtl/pause_prio_arb.sv
// -----------------------------------------------------------------------------
// pause_prio_arb
// Combinational fixed-priority one-hot picker. Index 0 has the highest
// priority. The sequencer registers the result, so no state lives here.
// Ports:
//   req  in  NREQ  request vector
//   pick out NREQ  one-hot lowest-index set bit of req, zero when req is zero
// -----------------------------------------------------------------------------
module pause_prio_arb #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] pick
);

   // Two's-complement trick: req & -req isolates the lowest set bit.
   assign pick = req & (~req + NREQ'(1));

endmodule

// File: rtl/pause_sequencer.sv
// -----------------------------------------------------------------------------
// pause_sequencer
// Frame-aligned pause controller between the pause sources (user button, OSD,
// NREQ external requesters) and the CPU/video core. The CPU is halted only on a
// vblank rising edge, the bus is then handed to one external requester at a
// time, and the CPU resumes on a later vblank rising edge. A dim timer raises
// dim_video after the CPU has stayed paused for DIM_CYCLES cycles.
//
// Parameters:
//   NREQ       number of external requesters, index 0 highest priority
//   CLKSPD     clk_sys frequency in MHz
//   DIM_SECS   paused seconds before dimming
//   DIM_CYCLES derived dim threshold in cycles (override only to shorten it)
// Ports:
//   clk_sys      in   1     system clock
//   reset        in   1     synchronous, active-high
//   user_button  in   1     user pause button; each rising edge toggles pause
//   osd_status   in   1     OSD open
//   options      in   2     [0] pause while OSD open, [1] dimming enabled
//   req          in   NREQ  external pause/bus requests
//   vblank       in   1     vertical blank, synchronous to clk_sys
//   cpu_halt_ack in   1     CPU stopped and bus free
//   pause_cpu    out  1     halt request to the CPU
//   paused       out  1     CPU confirmed halted
//   grant        out  NREQ  one-hot bus grant, zero when none
//   dim_video    out  1     video dimming requested
//   state_dbg    out  3     current sequencer state
// -----------------------------------------------------------------------------
module pause_sequencer
   import pause_pkg::*;
#(
   parameter int unsigned NREQ       = 2,
   parameter int unsigned CLKSPD     = 12,
   parameter int unsigned DIM_SECS   = 10,
   parameter logic [31:0] DIM_CYCLES = dim_cycles(CLKSPD, DIM_SECS)
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic            user_button,
   input  logic            osd_status,
   input  logic [1:0]      options,
   input  logic [NREQ-1:0] req,
   input  logic            vblank,
   input  logic            cpu_halt_ack,
   output logic            pause_cpu,
   output logic            paused,
   output logic [NREQ-1:0] grant,
   output logic            dim_video,
   output pause_state_t    state_dbg
);

   // Request/grant handshake: a requester raises req[i] and holds it high for
   // the whole time it needs the bus. grant[i] is only ever set while PAUSED,
   // is never taken away while req[i] stays high, and falls the cycle after
   // req[i] is sampled low. After a grant falls there is always one idle cycle
   // before the next requester is picked.

   logic            btn_d;
   logic            user_tog;
   logic            vblank_d;
   logic            btn_rise;
   logic            vbl_edge;
   logic            src;
   pause_state_t    state;
   pause_state_t    state_nxt;
   logic [NREQ-1:0] pick;
   logic [31:0]     dim_cnt;
   logic [31:0]     dim_cnt_nxt;

   assign btn_rise  = user_button & ~btn_d;
   assign vbl_edge  = vblank & ~vblank_d;
   assign src       = user_tog | (osd_status & options[OPT_OSD_PAUSE]) | (|req);
   assign state_dbg = state;

   pause_prio_arb #(.NREQ(NREQ)) u_arb (
      .req  (req),
      .pick (pick)
   );

   // Input edge detectors and the user toggle. During reset btn_d follows the
   // button so a press coinciding with reset is swallowed instead of producing
   // a toggle right after release. vblank_d resets high so a vblank already
   // asserted at reset release is not mistaken for a fresh frame boundary.
   always_ff @(posedge clk_sys) begin
      btn_d <= user_button;
      if (reset) begin
         user_tog <= 1'b0;
         vblank_d <= 1'b1;
      end else begin
         vblank_d <= vblank;
         if (btn_rise) begin
            user_tog <= ~user_tog;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (src) state_nxt = WAIT_VBL;
         WAIT_VBL: begin
            if (!src)          state_nxt = RUN;
            else if (vbl_edge) state_nxt = HALTING;
         end
         // No abort from here: the CPU is already being stopped.
         HALTING:  if (cpu_halt_ack) state_nxt = PAUSED;
         PAUSED:   if (!src && (grant == '0)) state_nxt = RESUMING;
         RESUMING: begin
            if (src)           state_nxt = PAUSED;
            else if (vbl_edge) state_nxt = RUN;
         end
         default:  state_nxt = RUN;
      endcase
   end

   // Saturating dim counter; cleared whenever not paused or dimming disabled.
   always_comb begin
      dim_cnt_nxt = '0;
      if ((state == PAUSED) && options[OPT_DIM_EN]) begin
         dim_cnt_nxt = (dim_cnt >= DIM_CYCLES) ? DIM_CYCLES : dim_cnt + 32'd1;
      end
   end

   // Outputs are registered from the next-state values so they line up with
   // the state register itself.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state     <= RUN;
         pause_cpu <= 1'b0;
         paused    <= 1'b0;
         grant     <= '0;
         dim_cnt   <= '0;
         dim_video <= 1'b0;
      end else begin
         state     <= state_nxt;
         pause_cpu <= (state_nxt == HALTING) || (state_nxt == PAUSED) ||
                      (state_nxt == RESUMING);
         paused    <= (state_nxt == PAUSED);
         dim_cnt   <= dim_cnt_nxt;
         dim_video <= (dim_cnt_nxt == DIM_CYCLES);
         if (state == PAUSED) begin
            if (grant == '0) begin
               grant <= pick;
            end else if ((grant & req) == '0) begin
               grant <= '0;
            end
         end else begin
            grant <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pause_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pause_sequencer
// Self-checking bench for pause_sequencer: a table of per-cycle input/expected
// output records covering arbitration, abort/re-entry, simultaneous events and
// reset, followed by hand-written multi-cycle sequences for the user pause,
// the dim timer and reset while halting.
// -----------------------------------------------------------------------------
module tb_pause_sequencer;
   import pause_pkg::*;

   localparam int          NREQ = 2;
   localparam logic [31:0] DIMC = 32'd300;
   localparam int          W    = 8;

   logic            clk_sys = 1'b0;
   logic            reset;
   logic            user_button;
   logic            osd_status;
   logic [1:0]      options;
   logic [NREQ-1:0] req;
   logic            vblank;
   logic            cpu_halt_ack;
   logic            pause_cpu;
   logic            paused;
   logic [NREQ-1:0] grant;
   logic            dim_video;
   pause_state_t    state_dbg;

   // ---------------- clock / reset ----------------
   always #5 clk_sys = ~clk_sys;

   pause_sequencer #(
      .NREQ       (NREQ),
      .CLKSPD     (1),
      .DIM_SECS   (1),
      .DIM_CYCLES (DIMC)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .user_button  (user_button),
      .osd_status   (osd_status),
      .options      (options),
      .req          (req),
      .vblank       (vblank),
      .cpu_halt_ack (cpu_halt_ack),
      .pause_cpu    (pause_cpu),
      .paused       (paused),
      .grant        (grant),
      .dim_video    (dim_video),
      .state_dbg    (state_dbg)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   function automatic logic [W-1:0] pack(input pause_state_t st, input logic pc,
                                         input logic pd, input logic [1:0] gr,
                                         input logic dm);
      return {st, pc, pd, gr, dm};
   endfunction

   // Inputs are already driven; push the expectation, let one rising edge
   // pass, then pop and compare on the falling edge.
   task automatic step(input string nm, input pause_state_t st, input logic pc,
                       input logic pd, input logic [1:0] gr, input logic dm);
      logic [W-1:0] e;
      logic [W-1:0] a;
      exp_q.push_back(pack(st, pc, pd, gr, dm));
      @(posedge clk_sys);
      @(negedge clk_sys);
      e = exp_q.pop_front();
      a = {state_dbg, pause_cpu, paused, grant, dim_video};
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s t=%0t got st=%0d pc=%b pd=%b gr=%b dm=%b want st=%0d pc=%b pd=%b gr=%b dm=%b",
                  nm, $time, a[7:5], a[4], a[3], a[2:1], a[0],
                  e[7:5], e[4], e[3], e[2:1], e[0]);
      end
   endtask

   task automatic hold(input int n, input string nm, input pause_state_t st,
                       input logic pc, input logic pd, input logic [1:0] gr,
                       input logic dm);
      for (int i = 0; i < n; i++) step(nm, st, pc, pd, gr, dm);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         rst;
      logic         btn;
      logic         osd;
      logic [1:0]   opt;
      logic [1:0]   rq;
      logic         vbl;
      logic         ack;
      pause_state_t st;
      logic         pc;
      logic         pd;
      logic [1:0]   gr;
      logic         dm;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic rst, input logic btn, input logic osd,
                              input logic [1:0] opt, input logic [1:0] rq,
                              input logic vbl, input logic ack,
                              input pause_state_t st, input logic pc,
                              input logic pd, input logic [1:0] gr);
      vec_t r;
      r.rst = rst; r.btn = btn; r.osd = osd; r.opt = opt; r.rq = rq;
      r.vbl = vbl; r.ack = ack; r.st = st; r.pc = pc; r.pd = pd; r.gr = gr;
      r.dm  = 1'b0;
      return r;
   endfunction

   initial begin
      reset = 1'b1; user_button = 1'b0; osd_status = 1'b0; options = 2'b00;
      req = '0; vblank = 1'b0; cpu_halt_ack = 1'b0;

      //               rst btn osd opt    req    vbl ack  state     pc pd grant
      // reset state
      vecs.push_back(v(1, 0, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(1, 0, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      // OSD pause aborted before any vblank edge
      vecs.push_back(v(0, 0, 1, 2'b01, 2'b00, 0, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 1, 2'b01, 2'b00, 0, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b01, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b01, 2'b00, 1, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      // two requesters: halt, grant 01, gap, grant 10, no preemption, resume
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b11, 0, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b11, 1, 0, HALTING,  1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b11, 0, 0, HALTING,  1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b11, 0, 1, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b11, 0, 0, PAUSED,   1, 1, 2'b01));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b11, 0, 0, PAUSED,   1, 1, 2'b01));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b10, 0, 0, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b10, 0, 0, PAUSED,   1, 1, 2'b10));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b11, 0, 0, PAUSED,   1, 1, 2'b10));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b10, 0, 0, PAUSED,   1, 1, 2'b10));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RESUMING, 1, 0, 2'b00));
      // OSD re-raised during RESUMING, then drop and resume on vblank edge
      vecs.push_back(v(0, 0, 1, 2'b01, 2'b00, 0, 0, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b01, 2'b00, 0, 0, RESUMING, 1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b01, 2'b00, 1, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b01, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      // src drop together with vblank edge in WAIT_VBL goes to RUN
      vecs.push_back(v(0, 0, 1, 2'b01, 2'b00, 0, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b01, 2'b00, 1, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      // src return together with vblank edge in RESUMING goes to PAUSED
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 0, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 1, 0, HALTING,  1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 0, 1, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 0, 0, PAUSED,   1, 1, 2'b01));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RESUMING, 1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 1, 0, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 0, 0, PAUSED,   1, 1, 2'b01));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RESUMING, 1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 1, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      // src drop in HALTING does not abort
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 0, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 1, 0, HALTING,  1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, HALTING,  1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, HALTING,  1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 1, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RESUMING, 1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 1, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      // reset in HALTING with vblank held high across release
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 0, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 1, 0, HALTING,  1, 0, 2'b00));
      vecs.push_back(v(1, 0, 0, 2'b00, 2'b01, 1, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 1, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 1, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 0, 0, WAIT_VBL, 0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b01, 1, 0, HALTING,  1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 1, PAUSED,   1, 1, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RESUMING, 1, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 1, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      // button edge in the same cycle as reset: toggle must not happen
      vecs.push_back(v(1, 1, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 1, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 1, 0, RUN,      0, 0, 2'b00));
      vecs.push_back(v(0, 0, 0, 2'b00, 2'b00, 0, 0, RUN,      0, 0, 2'b00));

      // ---------------- driver: table ----------------
      foreach (vecs[i]) begin
         reset        = vecs[i].rst;
         user_button  = vecs[i].btn;
         osd_status   = vecs[i].osd;
         options      = vecs[i].opt;
         req          = vecs[i].rq;
         vblank       = vecs[i].vbl;
         cpu_halt_ack = vecs[i].ack;
         step($sformatf("vec%0d", i), vecs[i].st, vecs[i].pc, vecs[i].pd,
              vecs[i].gr, vecs[i].dm);
      end

      // ---------------- user pause with dimming ----------------
      reset = 1'b0; osd_status = 1'b0; req = '0; vblank = 1'b0;
      cpu_halt_ack = 1'b0; options = 2'b10;
      user_button = 1'b1; step("u_btn_rise", RUN, 0, 0, 2'b00, 0);
      user_button = 1'b0; step("u_wait", WAIT_VBL, 0, 0, 2'b00, 0);
      hold(98, "u_wait_frame", WAIT_VBL, 0, 0, 2'b00, 0);
      vblank = 1'b1; step("u_halt_edge", HALTING, 1, 0, 2'b00, 0);
      vblank = 1'b0; hold(4, "u_halting", HALTING, 1, 0, 2'b00, 0);
      cpu_halt_ack = 1'b1; step("u_paused", PAUSED, 1, 1, 2'b00, 0);
      cpu_halt_ack = 1'b0;
      hold(int'(DIMC) - 1, "u_dim_low", PAUSED, 1, 1, 2'b00, 0);
      step("u_dim_rise", PAUSED, 1, 1, 2'b00, 1);
      hold(3, "u_dim_sat", PAUSED, 1, 1, 2'b00, 1);
      options = 2'b00; step("u_dim_off", PAUSED, 1, 1, 2'b00, 0);
      options = 2'b10;
      hold(int'(DIMC) - 1, "u_dim_relow", PAUSED, 1, 1, 2'b00, 0);
      step("u_dim_rerise", PAUSED, 1, 1, 2'b00, 1);
      user_button = 1'b1; step("u_btn2", PAUSED, 1, 1, 2'b00, 1);
      user_button = 1'b0; step("u_resuming", RESUMING, 1, 0, 2'b00, 1);
      step("u_dim_fall", RESUMING, 1, 0, 2'b00, 0);
      hold(5, "u_resume_wait", RESUMING, 1, 0, 2'b00, 0);
      vblank = 1'b1; step("u_resume_edge", RUN, 0, 0, 2'b00, 0);
      vblank = 1'b0; step("u_run", RUN, 0, 0, 2'b00, 0);

      // ---------------- reset while halting on a user pause ----------------
      options = 2'b00;
      user_button = 1'b1; step("r_btn", RUN, 0, 0, 2'b00, 0);
      user_button = 1'b0; step("r_wait", WAIT_VBL, 0, 0, 2'b00, 0);
      vblank = 1'b1; step("r_halt", HALTING, 1, 0, 2'b00, 0);
      reset = 1'b1; step("r_reset", RUN, 0, 0, 2'b00, 0);
      reset = 1'b0; hold(3, "r_vbl_high", RUN, 0, 0, 2'b00, 0);
      vblank = 1'b0; step("r_vbl_low", RUN, 0, 0, 2'b00, 0);
      vblank = 1'b1; step("r_tog_clear", RUN, 0, 0, 2'b00, 0);
      vblank = 1'b0; step("r_idle", RUN, 0, 0, 2'b00, 0);

      // ---------------- report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
